// File: rtl/xe4_vram_arbiter_if.sv
// Bus bundle between the three video-RAM requesters, the arbiter and the RAM macro.
//
// Handshake: a requester raises <who>_req together with addr/we/wdata and keeps
// them stable until <who>_gnt is high in the same cycle. gnt is combinational
// from req and arbiter state. In the cycle after a grant the requester drops req
// or presents its next request. A granted read returns <who>_rvalid for one
// cycle, two cycles after the grant, with the data on the shared rdata bus.
interface xe4_vram_arbiter_if;
    // Display scan-out (read only)
    logic        disp_req;
    logic [14:0] disp_addr;
    logic        disp_gnt;
    logic        disp_rvalid;
    // CPU video port
    logic        cpu_req;
    logic        cpu_we;
    logic [14:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_gnt;
    logic        cpu_rvalid;
    // Block-copy engine
    logic        dma_req;
    logic        dma_we;
    logic [14:0] dma_addr;
    logic [7:0]  dma_wdata;
    logic        dma_gnt;
    logic        dma_rvalid;
    // Shared read return and RAM side
    logic [7:0]  rdata;
    logic [14:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;

    // Requester / RAM side of the bundle
    modport master (
        output disp_req, disp_addr,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        output mem_rdata,
        input  disp_gnt, disp_rvalid, cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid,
        input  rdata, mem_addr, mem_wdata, mem_we
    );

    // Arbiter side of the bundle
    modport slave (
        input  disp_req, disp_addr,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        input  mem_rdata,
        output disp_gnt, disp_rvalid, cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid,
        output rdata, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/xe4_vram_arbiter.sv
// Video RAM arbiter: one access per clock shared between display scan-out
// (fixed top priority with an anti-starvation run limit), the CPU and the DMA
// engine (round-robin between the two). RAM controls are registered; read data
// is routed back to the originator two cycles after its grant.
module xe4_vram_arbiter #(
    parameter int MAX_DISP_RUN = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    xe4_vram_arbiter_if.slave    bus,
    output logic [3:0]           o_dbg_run_cnt,
    output logic                 o_dbg_rr
);

    localparam logic [3:0] RUN_MAX = 4'(MAX_DISP_RUN);

    // Arbitration state
    logic [3:0]  r_run_cnt;
    logic        r_rr;          // 0: CPU wins next CPU/DMA tie, 1: DMA wins
    // Registered RAM controls
    logic [14:0] r_mem_addr;
    logic [7:0]  r_mem_wdata;
    logic        r_mem_we;
    // Read tags, one-hot {dma, cpu, disp}; stage 2 lines up with mem_rdata
    logic [2:0]  r_tag1;
    logic [2:0]  r_tag2;

    logic        w_pend;
    logic        w_disp_mask;
    logic        w_disp_gnt;
    logic        w_cpu_gnt;
    logic        w_dma_gnt;
    logic        w_any_gnt;
    logic [3:0]  w_run_cnt_nxt;
    logic        w_rr_nxt;
    logic [2:0]  w_rd_tag;
    logic [14:0] w_sel_addr;
    logic [7:0]  w_sel_wdata;
    logic        w_sel_we;

    // Grant decode: DISP first unless its run limit is hit, then CPU/DMA by rr
    always_comb begin
        w_pend      = bus.cpu_req | bus.dma_req;
        w_disp_mask = w_pend && (r_run_cnt >= RUN_MAX);
        w_disp_gnt  = 1'b0;
        w_cpu_gnt   = 1'b0;
        w_dma_gnt   = 1'b0;
        if (!rst) begin
            if (bus.disp_req && !w_disp_mask) begin
                w_disp_gnt = 1'b1;
            end else if (bus.cpu_req && bus.dma_req) begin
                if (r_rr) begin
                    w_dma_gnt = 1'b1;
                end else begin
                    w_cpu_gnt = 1'b1;
                end
            end else if (bus.cpu_req) begin
                w_cpu_gnt = 1'b1;
            end else if (bus.dma_req) begin
                w_dma_gnt = 1'b1;
            end
        end
        w_any_gnt = w_disp_gnt | w_cpu_gnt | w_dma_gnt;
    end

    // Next run count and round-robin pointer; run count only grows while DISP
    // keeps winning against pending CPU/DMA traffic
    always_comb begin
        w_run_cnt_nxt = 4'd0;
        if (w_disp_gnt && w_pend) begin
            w_run_cnt_nxt = (r_run_cnt >= RUN_MAX) ? RUN_MAX : r_run_cnt + 4'd1;
        end
        w_rr_nxt = r_rr;
        if (w_cpu_gnt) begin
            w_rr_nxt = 1'b1;
        end else if (w_dma_gnt) begin
            w_rr_nxt = 1'b0;
        end
    end

    // Winner's access fields and read tag; DISP never writes, so its wdata
    // slot just keeps the previous value
    always_comb begin
        w_sel_addr  = r_mem_addr;
        w_sel_wdata = r_mem_wdata;
        w_sel_we    = 1'b0;
        if (w_disp_gnt) begin
            w_sel_addr = bus.disp_addr;
        end else if (w_cpu_gnt) begin
            w_sel_addr  = bus.cpu_addr;
            w_sel_wdata = bus.cpu_wdata;
            w_sel_we    = bus.cpu_we;
        end else if (w_dma_gnt) begin
            w_sel_addr  = bus.dma_addr;
            w_sel_wdata = bus.dma_wdata;
            w_sel_we    = bus.dma_we;
        end
        w_rd_tag = {w_dma_gnt & ~bus.dma_we, w_cpu_gnt & ~bus.cpu_we, w_disp_gnt};
    end

    // State, RAM controls and read-tag pipeline; reset drops in-flight reads
    always_ff @(posedge clk) begin
        if (rst) begin
            r_run_cnt   <= 4'd0;
            r_rr        <= 1'b0;
            r_mem_addr  <= 15'd0;
            r_mem_wdata <= 8'd0;
            r_mem_we    <= 1'b0;
            r_tag1      <= 3'd0;
            r_tag2      <= 3'd0;
        end else begin
            r_run_cnt <= w_run_cnt_nxt;
            r_rr      <= w_rr_nxt;
            r_tag1    <= w_rd_tag;
            r_tag2    <= r_tag1;
            r_mem_we  <= w_sel_we;
            if (w_any_gnt) begin
                r_mem_addr  <= w_sel_addr;
                r_mem_wdata <= w_sel_wdata;
            end
        end
    end

    assign bus.disp_gnt    = w_disp_gnt;
    assign bus.cpu_gnt     = w_cpu_gnt;
    assign bus.dma_gnt     = w_dma_gnt;
    assign bus.disp_rvalid = r_tag2[0];
    assign bus.cpu_rvalid  = r_tag2[1];
    assign bus.dma_rvalid  = r_tag2[2];
    assign bus.rdata       = (|r_tag2) ? bus.mem_rdata : 8'h00;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_wdata   = r_mem_wdata;
    assign bus.mem_we      = r_mem_we;
    assign o_dbg_run_cnt   = r_run_cnt;
    assign o_dbg_rr        = r_rr;

endmodule

// File: tb/tb_xe4_vram_arbiter.sv
// Directed bench for xe4_vram_arbiter with a synchronous 32K x 8 RAM model.
module tb_xe4_vram_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  dbg_run_cnt;
  logic        dbg_rr;
  logic        pre_we;
  logic [14:0] pre_addr;
  logic [7:0]  pre_data;
  logic [7:0]  ram [0:32767];

  int n_checks;
  int n_fail;
  logic [7:0] exp_q [$];

  // {disp,cpu,dma,we} request, expected {disp,cpu,dma} grant, state after the edge
  typedef struct {
    logic [3:0] req;
    logic [2:0] gnt;
    logic [3:0] run;
    logic       rr;
  } vec_t;
  vec_t vecs [$];

  xe4_vram_arbiter_if bus ();

  xe4_vram_arbiter #(.MAX_DISP_RUN(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .o_dbg_run_cnt (dbg_run_cnt),
    .o_dbg_rr      (dbg_rr)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  // synchronous RAM, 1-cycle read latency, bench-side preload port
  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic [3:0] req, input logic [2:0] gnt, input logic [3:0] run, input logic rr);
    vec_t v;
    v.req = req; v.gnt = gnt; v.run = run; v.rr = rr;
    vecs.push_back(v);
  endtask

  task automatic drive_req(input logic [3:0] req);
    bus.disp_req = req[3];
    bus.cpu_req  = req[2];
    bus.dma_req  = req[1];
    bus.cpu_we   = req[0];
    bus.dma_we   = req[0];
  endtask

  task automatic preload(input logic [14:0] a, input logic [7:0] d);
    pre_addr = a; pre_data = d; pre_we = 1'b1;
    tick();
    pre_we = 1'b0;
  endtask

  // single CPU read: grant in n, address in n+1, data in n+2
  task automatic cpu_read_check(input logic [14:0] a, input logic [7:0] d);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = a;
    #1;
    chk("rd_cpu_gnt", 32'(bus.cpu_gnt), 32'h1);
    chk("rd_other_gnt", 32'({bus.disp_gnt, bus.dma_gnt}), 32'h0);
    tick();
    bus.cpu_req = 1'b0;
    #1;
    chk("rd_mem_addr", 32'(bus.mem_addr), 32'(a));
    chk("rd_mem_we", 32'(bus.mem_we), 32'h0);
    chk("rd_early_rvalid", 32'(bus.cpu_rvalid), 32'h0);
    tick();
    chk("rd_cpu_rvalid", 32'(bus.cpu_rvalid), 32'h1);
    chk("rd_rdata", 32'(bus.rdata), 32'(d));
    chk("rd_other_rvalid", 32'({bus.disp_rvalid, bus.dma_rvalid}), 32'h0);
    tick();
    chk("rd_rvalid_pulse", 32'(bus.cpu_rvalid), 32'h0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    bus.disp_addr = 15'h0; bus.cpu_addr = 15'h0; bus.dma_addr = 15'h0;
    bus.cpu_wdata = 8'h0; bus.dma_wdata = 8'h0;

    // ---- reset with every request raised
    rst = 1'b1;
    drive_req(4'b1110);
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_gnt", 32'({bus.disp_gnt, bus.cpu_gnt, bus.dma_gnt}), 32'h0);
      chk("rst_rvalid", 32'({bus.disp_rvalid, bus.cpu_rvalid, bus.dma_rvalid}), 32'h0);
      chk("rst_mem_we", 32'(bus.mem_we), 32'h0);
    end
    rst = 1'b0;
    drive_req(4'b0000);
    #1;
    chk("post_rst_mem_we", 32'(bus.mem_we), 32'h0);
    chk("post_rst_rvalid", 32'({bus.disp_rvalid, bus.cpu_rvalid, bus.dma_rvalid}), 32'h0);
    chk("post_rst_mem_addr", 32'(bus.mem_addr), 32'h0);
    chk("post_rst_state", 32'({dbg_run_cnt, dbg_rr}), 32'h0);
    tick();

    // ---- arbitration table: CPU/DMA alternation, DISP run limit, rr hold
    add_vec(4'b0111, 3'b010, 4'd0, 1'b1);
    add_vec(4'b0111, 3'b001, 4'd0, 1'b0);
    add_vec(4'b0111, 3'b010, 4'd0, 1'b1);
    add_vec(4'b0111, 3'b001, 4'd0, 1'b0);
    add_vec(4'b0011, 3'b001, 4'd0, 1'b0);
    add_vec(4'b0101, 3'b010, 4'd0, 1'b1);
    add_vec(4'b0011, 3'b001, 4'd0, 1'b0);
    add_vec(4'b0000, 3'b000, 4'd0, 1'b0);
    add_vec(4'b1000, 3'b100, 4'd0, 1'b0);
    add_vec(4'b1000, 3'b100, 4'd0, 1'b0);
    add_vec(4'b1100, 3'b100, 4'd1, 1'b0);
    add_vec(4'b1100, 3'b100, 4'd2, 1'b0);
    add_vec(4'b1100, 3'b100, 4'd3, 1'b0);
    add_vec(4'b1100, 3'b100, 4'd4, 1'b0);
    add_vec(4'b1100, 3'b010, 4'd0, 1'b1);
    add_vec(4'b1110, 3'b100, 4'd1, 1'b1);
    add_vec(4'b1110, 3'b100, 4'd2, 1'b1);
    add_vec(4'b1110, 3'b100, 4'd3, 1'b1);
    add_vec(4'b1110, 3'b100, 4'd4, 1'b1);
    add_vec(4'b1110, 3'b001, 4'd0, 1'b0);
    add_vec(4'b1010, 3'b100, 4'd1, 1'b0);
    add_vec(4'b0010, 3'b001, 4'd0, 1'b0);
    add_vec(4'b1000, 3'b100, 4'd0, 1'b0);
    add_vec(4'b1100, 3'b100, 4'd1, 1'b0);
    add_vec(4'b1000, 3'b100, 4'd0, 1'b0);
    add_vec(4'b0000, 3'b000, 4'd0, 1'b0);
    for (int i = 0; i < vecs.size(); i++) begin
      bus.disp_addr = 15'(16'h7200 + i);
      bus.cpu_addr  = 15'(16'h7000 + i);
      bus.dma_addr  = 15'(16'h7100 + i);
      bus.cpu_wdata = 8'(i);
      bus.dma_wdata = 8'(8'h80 + i);
      drive_req(vecs[i].req);
      #1;
      chk($sformatf("vec%0d_gnt", i), 32'({bus.disp_gnt, bus.cpu_gnt, bus.dma_gnt}), 32'(vecs[i].gnt));
      tick();
      chk($sformatf("vec%0d_run", i), 32'(dbg_run_cnt), 32'(vecs[i].run));
      chk($sformatf("vec%0d_rr", i), 32'(dbg_rr), 32'(vecs[i].rr));
    end
    drive_req(4'b0000);
    tick();
    tick();

    // ---- single CPU read of a preloaded location
    preload(15'h1234, 8'hA5);
    cpu_read_check(15'h1234, 8'hA5);

    // ---- CPU write, then DMA reads it back
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 15'h0100; bus.cpu_wdata = 8'h3C;
    #1;
    chk("wr_cpu_gnt", 32'(bus.cpu_gnt), 32'h1);
    tick();
    bus.cpu_req = 1'b0;
    #1;
    chk("wr_mem_we", 32'(bus.mem_we), 32'h1);
    chk("wr_mem_addr", 32'(bus.mem_addr), 32'h0100);
    chk("wr_mem_wdata", 32'(bus.mem_wdata), 32'h3C);
    tick();
    chk("wr_mem_we_off", 32'(bus.mem_we), 32'h0);
    chk("wr_no_rvalid", 32'(bus.cpu_rvalid), 32'h0);
    chk("wr_addr_hold", 32'(bus.mem_addr), 32'h0100);
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 15'h0100;
    #1;
    chk("rb_dma_gnt", 32'(bus.dma_gnt), 32'h1);
    tick();
    bus.dma_req = 1'b0;
    tick();
    chk("rb_dma_rvalid", 32'(bus.dma_rvalid), 32'h1);
    chk("rb_rdata", 32'(bus.rdata), 32'h3C);
    tick();

    // ---- back-to-back reads DISP, CPU, DMA; returns in grant order
    preload(15'h0000, 8'h11);
    preload(15'h0001, 8'h22);
    preload(15'h0002, 8'h33);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    bus.disp_req = 1'b1; bus.disp_addr = 15'h0000;
    #1;
    chk("b2b_disp_gnt", 32'(bus.disp_gnt), 32'h1);
    tick();
    bus.disp_req = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 15'h0001;
    #1;
    chk("b2b_cpu_gnt", 32'(bus.cpu_gnt), 32'h1);
    chk("b2b_rvalid_n1", 32'({bus.disp_rvalid, bus.cpu_rvalid, bus.dma_rvalid}), 32'h0);
    tick();
    bus.cpu_req = 1'b0;
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 15'h0002;
    #1;
    chk("b2b_dma_gnt", 32'(bus.dma_gnt), 32'h1);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("b2b_rvalid%0d", k), 32'({bus.disp_rvalid, bus.cpu_rvalid, bus.dma_rvalid}),
          32'(3'b100 >> k));
      if (exp_q.size() > 0) chk($sformatf("b2b_rdata%0d", k), 32'(bus.rdata), 32'(exp_q.pop_front()));
      tick();
      bus.dma_req = 1'b0;
    end
    chk("b2b_rvalid_end", 32'({bus.disp_rvalid, bus.cpu_rvalid, bus.dma_rvalid}), 32'h0);
    chk("b2b_queue_empty", 32'(exp_q.size()), 32'h0);

    // ---- reset the cycle after a CPU read grant
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 15'h1234;
    #1;
    chk("mid_cpu_gnt", 32'(bus.cpu_gnt), 32'h1);
    tick();
    bus.cpu_req = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_mem_addr", 32'(bus.mem_addr), 32'h1234);
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rvalid", 32'(bus.cpu_rvalid), 32'h0);
    chk("mid_mem_we", 32'(bus.mem_we), 32'h0);
    chk("mid_mem_addr_clr", 32'(bus.mem_addr), 32'h0);
    tick();
    chk("mid_rvalid_late", 32'(bus.cpu_rvalid), 32'h0);
    cpu_read_check(15'h1234, 8'hA5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
